mem_read_arbiter: RTL and testbench
===================================

Name: mem_read_arbiter

Overview:
- Shares the single AXI-style memory read port between the instruction cache refill master (requester 0, IC) and the data cache refill master (requester 1, DC).
- Grants one whole burst at a time: address phase, then all data beats routed back to the owner.
- Round-robin between requesters, so neither cache can starve the other.
- Sits between the two cache refill FSMs and the memory read channel.

Parameters:
- ADDR_WIDTH, 26: byte-address width, equal to the core address width.
- DATA_WIDTH, 32: beat width.
- LEN_WIDTH, 8: burst length field width. ARLEN is a beat count: 4 means 4 beats, not len-1.
- FIXED_PRIO, 0: 0 selects round-robin. 1 means IC always wins ties.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- ic_araddr  in  ADDR_WIDTH  IC burst address
- ic_arlen  in  LEN_WIDTH  IC beat count
- ic_arvalid  in  1  IC request; held until ic_arready
- ic_arready  out  1  IC address accepted
- ic_rdata  out  DATA_WIDTH  read data to IC
- ic_rvalid  out  1  beat valid for IC
- ic_rready  in  1  IC can take a beat
- dc_araddr, dc_arlen, dc_arvalid, dc_arready, dc_rdata, dc_rvalid, dc_rready: same as the ic_* ports, for DC
- mem_araddr  out  ADDR_WIDTH  to memory
- mem_arlen  out  LEN_WIDTH  to memory
- mem_arid  out  4  {3'b0, owner}
- mem_arvalid  out  1  to memory
- mem_arready  in  1  from memory
- mem_rdata  in  DATA_WIDTH  from memory
- mem_rvalid  in  1  from memory
- mem_rready  out  1  to memory
- owner  out  1  current/last grant (0 = IC, 1 = DC)
- busy  out  1  high in ADDR or DATA state
- err_spurious_r  out  1  sticky; a beat arrived with no burst outstanding

Behaviour:
- State machine with states IDLE, ADDR, DATA.
- IDLE:
  - If no requester is valid, stay in IDLE.
  - If exactly one requester is valid, grant it.
  - If both are valid, grant the requester that was not granted last (last_grant pointer). With FIXED_PRIO=1, grant IC.
  - On grant, register owner, address and length, then go to ADDR.
  - Latency: a request first seen in cycle t produces mem_arvalid=1 in cycle t+1.
- ADDR:
  - mem_arvalid=1, driven from the registered address, length and id.
  - When mem_arready=1: the owner's arready is asserted for exactly that cycle, beats_left is loaded with len, and the FSM goes to DATA.
  - The non-owner's arready stays 0 throughout.
- ARLEN of 0 is treated as 1 beat; beats_left is loaded with max(len, 1).
- DATA:
  - mem_rdata is broadcast to both ic_rdata and dc_rdata.
  - Only the owner sees rvalid = mem_rvalid; the non-owner's rvalid is 0.
  - mem_rready = owner's rready.
  - A beat is a cycle with mem_rvalid & mem_rready. Each beat decrements beats_left.
  - A beat with beats_left==1 ends the burst: go to IDLE and set last_grant = owner.
- Re-arbitration happens in the IDLE cycle after the last beat, so there is a one-cycle bubble between bursts.
- Worst-case wait for a continuously requesting master is one foreign burst.
- mem_rvalid in IDLE or ADDR:
  - The beat is not forwarded, and mem_rready=1 drains it.
  - err_spurious_r is set and stays set until rst.
- A requester dropping arvalid before arready is a protocol violation. The registered request is still issued; no check is made.
- Reset values:
  - state = IDLE; last_grant = 1, so IC wins the first tie.
  - owner = 0; beats_left = 0.
  - All valid/ready outputs = 0, except mem_rready = 1 in IDLE.
  - mem_araddr, mem_arlen, mem_arid = 0; ic_rdata and dc_rdata follow mem_rdata; busy = 0; err_spurious_r = 0.
- Reset mid-burst: return to IDLE next cycle. Outstanding memory beats after reset count as spurious only if memory is not also reset, which the environment guarantees.
- Registers are updated only on the clock edge; all routing is combinational from the registered owner and state.

Decomposition:
- Shared package mem_arb_pkg holds:
  - typedef enum arb_state_e {ARB_IDLE, ARB_ADDR, ARB_DATA};
  - typedef enum logic owner_e {OWNER_ICACHE = 0, OWNER_DCACHE = 1};
  - localparam ARB_ID_WIDTH = 4.
- One sub-module, mem_rr_pick: a 2-way round-robin pick from (req[1:0], last_grant, fixed_prio) giving (gnt_valid, gnt_idx). It is purely combinational; the pointer register lives in the parent.

Test Plan:
- IC alone, addr 0x0001040, len 4, memory ready immediately.
  - Expect: mem_arvalid the cycle after request with mem_araddr=0x0001040, mem_arid=0.
  - Expect: ic_arready pulses 1 cycle; 4 ic_rvalid beats; dc_rvalid always 0; busy drops after beat 4.
- IC and DC both valid in the same cycle after reset.
  - Expect: IC granted first, then DC with mem_arid=1 granted in the IDLE cycle after IC's last beat.
  - Repeat the simultaneous request: DC is granted first (alternation).
- Back-pressure: DC burst of 4 with dc_rready low for 3 cycles mid-burst.
  - Expect: mem_rready low for those cycles and exactly 4 beats delivered.
  - Expect: no state change during the stall.
- mem_arready withheld 5 cycles.
  - Expect: mem_arvalid and mem_araddr stable for all 5 cycles, and dc_arready not asserted until the accept cycle.
- mem_rvalid=1 while in IDLE.
  - Expect: err_spurious_r=1 and sticky; ic_rvalid=dc_rvalid=0.
  - Assert rst mid-burst (beat 2 of 4): state IDLE, err_spurious_r=0, and all outputs at reset values the next cycle.
- ic_arlen=0.
  - Expect: exactly one beat accepted, then return to IDLE.

Source files
------------

// File: rtl/mem_read_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the two-master memory read
//               arbiter (IC / DC refill sharing one read port).
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWNER_ICACHE = 1'b0,
        OWNER_DCACHE = 1'b1
    } owner_e;

    localparam int ARB_ID_WIDTH = 4;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_read_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_read_arbiter_if
// Description : Bundle of the IC, DC and memory read-channel signals around
//               the arbiter; slave = arbiter view, master = environment view.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_read_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 26,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
);
    logic [ADDR_WIDTH-1:0]   ic_araddr;
    logic [LEN_WIDTH-1:0]    ic_arlen;
    logic                    ic_arvalid;
    logic                    ic_arready;
    logic [DATA_WIDTH-1:0]   ic_rdata;
    logic                    ic_rvalid;
    logic                    ic_rready;

    logic [ADDR_WIDTH-1:0]   dc_araddr;
    logic [LEN_WIDTH-1:0]    dc_arlen;
    logic                    dc_arvalid;
    logic                    dc_arready;
    logic [DATA_WIDTH-1:0]   dc_rdata;
    logic                    dc_rvalid;
    logic                    dc_rready;

    logic [ADDR_WIDTH-1:0]   mem_araddr;
    logic [LEN_WIDTH-1:0]    mem_arlen;
    logic [ARB_ID_WIDTH-1:0] mem_arid;
    logic                    mem_arvalid;
    logic                    mem_arready;
    logic [DATA_WIDTH-1:0]   mem_rdata;
    logic                    mem_rvalid;
    logic                    mem_rready;

    modport slave (
        input  ic_araddr, ic_arlen, ic_arvalid, ic_rready,
        input  dc_araddr, dc_arlen, dc_arvalid, dc_rready,
        input  mem_arready, mem_rdata, mem_rvalid,
        output ic_arready, ic_rdata, ic_rvalid,
        output dc_arready, dc_rdata, dc_rvalid,
        output mem_araddr, mem_arlen, mem_arid, mem_arvalid, mem_rready
    );

    modport master (
        output ic_araddr, ic_arlen, ic_arvalid, ic_rready,
        output dc_araddr, dc_arlen, dc_arvalid, dc_rready,
        output mem_arready, mem_rdata, mem_rvalid,
        input  ic_arready, ic_rdata, ic_rvalid,
        input  dc_arready, dc_rdata, dc_rvalid,
        input  mem_araddr, mem_arlen, mem_arid, mem_arvalid, mem_rready
    );

endinterface : mem_read_arbiter_if
`default_nettype wire

// File: rtl/mem_read_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : mem_rr_pick
// Description : Combinational 2-way round-robin pick; the last-grant pointer
//               is held by the parent.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_rr_pick (
    input  wire logic [1:0] req,
    input  wire logic       last_grant,
    input  wire logic       fixed_prio,
    output logic            gnt_valid,
    output logic            gnt_idx
);

    always_comb begin
        gnt_valid = |req;
        gnt_idx   = 1'b0;
        case (req)
            2'b01:   gnt_idx = 1'b0;
            2'b10:   gnt_idx = 1'b1;
            // Tie: favour whoever did not win last time, unless IC is pinned.
            2'b11:   gnt_idx = fixed_prio ? 1'b0 : ~last_grant;
            default: gnt_idx = 1'b0;
        endcase
    end

endmodule : mem_rr_pick
`default_nettype wire

// File: rtl/mem_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_read_arbiter
// Description : Burst-granular arbiter sharing one memory read port between
//               the IC and DC refill masters (round-robin or fixed priority).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_read_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 26,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8,
    parameter int FIXED_PRIO = 0
) (
    input  wire logic        clk,
    input  wire logic        rst,
    mem_read_arbiter_if.slave bus,
    output logic             owner,
    output logic             busy,
    output logic             err_spurious_r
);

    arb_state_e            state_q,      state_d;
    owner_e                owner_q,      owner_d;
    owner_e                last_grant_q, last_grant_d;
    logic [ADDR_WIDTH-1:0] addr_q,       addr_d;
    logic [LEN_WIDTH-1:0]  len_q,        len_d;
    logic [LEN_WIDTH-1:0]  beats_left_q, beats_left_d;
    logic                  err_q,        err_d;

    logic gnt_valid;
    logic gnt_idx;

    logic ic_arready_w, dc_arready_w;
    logic ic_rvalid_w,  dc_rvalid_w;
    logic mem_arvalid_w, mem_rready_w;

    mem_rr_pick u_pick (
        .req        ({bus.dc_arvalid, bus.ic_arvalid}),
        .last_grant (last_grant_q == OWNER_DCACHE),
        .fixed_prio (FIXED_PRIO != 0),
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            owner_q      <= OWNER_ICACHE;
            last_grant_q <= OWNER_DCACHE;
            addr_q       <= '0;
            len_q        <= '0;
            beats_left_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            beats_left_q <= beats_left_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_grant_d  = last_grant_q;
        addr_d        = addr_q;
        len_d         = len_q;
        beats_left_d  = beats_left_q;
        err_d         = err_q;
        ic_arready_w  = 1'b0;
        dc_arready_w  = 1'b0;
        ic_rvalid_w   = 1'b0;
        dc_rvalid_w   = 1'b0;
        mem_arvalid_w = 1'b0;
        mem_rready_w  = 1'b1;

        case (state_q)
            ARB_IDLE: begin
                if (bus.mem_rvalid) begin
                    err_d = 1'b1;
                end
                if (gnt_valid) begin
                    owner_d = owner_e'(gnt_idx);
                    addr_d  = gnt_idx ? bus.dc_araddr : bus.ic_araddr;
                    len_d   = gnt_idx ? bus.dc_arlen  : bus.ic_arlen;
                    state_d = ARB_ADDR;
                end
            end

            ARB_ADDR: begin
                mem_arvalid_w = 1'b1;
                if (bus.mem_rvalid) begin
                    err_d = 1'b1;
                end
                if (bus.mem_arready) begin
                    if (owner_q == OWNER_DCACHE) begin
                        dc_arready_w = 1'b1;
                    end else begin
                        ic_arready_w = 1'b1;
                    end
                    // A zero-length request still moves one beat.
                    beats_left_d = (len_q == '0) ? LEN_WIDTH'(1) : len_q;
                    state_d      = ARB_DATA;
                end
            end

            ARB_DATA: begin
                if (owner_q == OWNER_DCACHE) begin
                    mem_rready_w = bus.dc_rready;
                    dc_rvalid_w  = bus.mem_rvalid;
                end else begin
                    mem_rready_w = bus.ic_rready;
                    ic_rvalid_w  = bus.mem_rvalid;
                end
                if (bus.mem_rvalid && mem_rready_w) begin
                    beats_left_d = beats_left_q - LEN_WIDTH'(1);
                    if (beats_left_q == LEN_WIDTH'(1)) begin
                        state_d      = ARB_IDLE;
                        last_grant_d = owner_q;
                    end
                end
            end

            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    assign bus.ic_arready  = ic_arready_w;
    assign bus.dc_arready  = dc_arready_w;
    assign bus.ic_rvalid   = ic_rvalid_w;
    assign bus.dc_rvalid   = dc_rvalid_w;
    assign bus.ic_rdata    = bus.mem_rdata;
    assign bus.dc_rdata    = bus.mem_rdata;
    assign bus.mem_araddr  = addr_q;
    assign bus.mem_arlen   = len_q;
    assign bus.mem_arid    = {{(ARB_ID_WIDTH-1){1'b0}}, owner_q == OWNER_DCACHE};
    assign bus.mem_arvalid = mem_arvalid_w;
    assign bus.mem_rready  = mem_rready_w;

    assign owner           = (owner_q == OWNER_DCACHE);
    assign busy            = (state_q != ARB_IDLE);
    assign err_spurious_r  = err_q;

endmodule : mem_read_arbiter
`default_nettype wire

// File: tb/tb_mem_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_read_arbiter
// Description : Directed/randomised bench for mem_read_arbiter with a
//               transaction-level grant-order and beat-routing model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_read_arbiter;

    localparam int ADDR_WIDTH = 26;
    localparam int DATA_WIDTH = 32;
    localparam int LEN_WIDTH  = 8;

    logic clk = 1'b0;
    logic rst;
    logic owner, busy, err_spurious_r;

    int vectors     = 0;
    int miscompares = 0;

    // Model state: who won the most recent completed burst, and sticky error.
    bit model_last;
    bit model_err;

    bit                    pend_ic, pend_dc;
    logic [ADDR_WIDTH-1:0] ic_addr, dc_addr;
    logic [LEN_WIDTH-1:0]  ic_len,  dc_len;

    mem_read_arbiter_if #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH)
    ) bus ();

    mem_read_arbiter #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH),
        .FIXED_PRIO (0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus.slave),
        .owner          (owner),
        .busy           (busy),
        .err_spurious_r (err_spurious_r)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: a lone requester wins; on a tie the one not served last wins.
    function automatic bit exp_pick(input bit ic, input bit dc);
        if (ic && !dc) return 1'b0;
        if (dc && !ic) return 1'b1;
        return !model_last;
    endfunction

    task automatic check_reset_outputs(input logic [DATA_WIDTH-1:0] rd);
        chk("rst_busy",     busy, 0);
        chk("rst_err",      err_spurious_r, 0);
        chk("rst_owner",    owner, 0);
        chk("rst_arvalid",  bus.mem_arvalid, 0);
        chk("rst_araddr",   bus.mem_araddr, 0);
        chk("rst_arlen",    bus.mem_arlen, 0);
        chk("rst_arid",     bus.mem_arid, 0);
        chk("rst_ic_arrdy", bus.ic_arready, 0);
        chk("rst_dc_arrdy", bus.dc_arready, 0);
        chk("rst_ic_rvld",  bus.ic_rvalid, 0);
        chk("rst_dc_rvld",  bus.dc_rvalid, 0);
        chk("rst_rready",   bus.mem_rready, 1);
        chk("rst_ic_rdata", bus.ic_rdata, rd);
        chk("rst_dc_rdata", bus.dc_rdata, rd);
    endtask

    // Presents a request cycle; the arbiter is IDLE here so nothing is issued yet.
    task automatic request(input bit ic, input bit dc,
                           input logic [ADDR_WIDTH-1:0] ia, input logic [LEN_WIDTH-1:0] il,
                           input logic [ADDR_WIDTH-1:0] da, input logic [LEN_WIDTH-1:0] dl);
        @(negedge clk);
        if (ic) begin
            bus.ic_arvalid = 1'b1; bus.ic_araddr = ia; bus.ic_arlen = il;
            pend_ic = 1'b1; ic_addr = ia; ic_len = il;
        end
        if (dc) begin
            bus.dc_arvalid = 1'b1; bus.dc_araddr = da; bus.dc_arlen = dl;
            pend_dc = 1'b1; dc_addr = da; dc_len = dl;
        end
        #1;
        chk("req_arvalid_lat", bus.mem_arvalid, 0);
        chk("req_busy",        busy, 0);
    endtask

    // One whole burst starting in its ADDR cycle; ends with the bubble IDLE cycle.
    task automatic run_burst(input bit who, input logic [ADDR_WIDTH-1:0] addr,
                             input logic [LEN_WIDTH-1:0] len, input int ar_delay,
                             input int stall_at, input int stall_n, input int rst_at,
                             output bit was_reset);
        int nbeats  = (len == 0) ? 1 : int'(len);
        int beat    = 0;
        int stalled = 0;
        bit stalling;
        logic [DATA_WIDTH-1:0] d;
        was_reset = 1'b0;
        for (int i = 0; i <= ar_delay; i++) begin
            @(negedge clk);
            bus.mem_arready = (i == ar_delay);
            #1;
            chk("arvalid",       bus.mem_arvalid, 1);
            chk("araddr",        bus.mem_araddr, addr);
            chk("arlen",         bus.mem_arlen, len);
            chk("arid",          bus.mem_arid, {3'b0, who});
            chk("owner_arready", who ? bus.dc_arready : bus.ic_arready, (i == ar_delay));
            chk("other_arready", who ? bus.ic_arready : bus.dc_arready, 0);
            chk("addr_busy",     busy, 1);
        end
        while (beat < nbeats) begin
            @(negedge clk);
            bus.mem_arready = 1'b0;
            if (who) begin bus.dc_arvalid = 1'b0; pend_dc = 1'b0; end
            else     begin bus.ic_arvalid = 1'b0; pend_ic = 1'b0; end
            stalling       = (beat == stall_at) && (stalled < stall_n);
            d              = $urandom;
            bus.mem_rdata  = d;
            bus.mem_rvalid = 1'b1;
            if (who) begin bus.dc_rready = !stalling; bus.ic_rready = 1'($urandom); end
            else     begin bus.ic_rready = !stalling; bus.dc_rready = 1'($urandom); end
            rst = (beat == rst_at);
            #1;
            chk("own_rvalid",  who ? bus.dc_rvalid : bus.ic_rvalid, 1);
            chk("oth_rvalid",  who ? bus.ic_rvalid : bus.dc_rvalid, 0);
            chk("ic_rdata",    bus.ic_rdata, d);
            chk("dc_rdata",    bus.dc_rdata, d);
            chk("mem_rready",  bus.mem_rready, !stalling);
            chk("data_owner",  owner, who);
            chk("data_busy",   busy, 1);
            chk("data_arvld",  bus.mem_arvalid, 0);
            if (rst) begin
                @(negedge clk);
                rst = 1'b0;
                bus.mem_rvalid = 1'b0;
                d = $urandom;
                bus.mem_rdata = d;
                #1;
                check_reset_outputs(d);
                model_last = 1'b1;
                model_err  = 1'b0;
                was_reset  = 1'b1;
                return;
            end
            if (stalling) stalled++;
            else          beat++;
        end
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        #1;
        chk("end_busy",    busy, 0);
        chk("end_arvalid", bus.mem_arvalid, 0);
        chk("end_rready",  bus.mem_rready, 1);
        chk("end_ic_rvld", bus.ic_rvalid, 0);
        chk("end_dc_rvld", bus.dc_rvalid, 0);
        chk("end_err",     err_spurious_r, model_err);
        model_last = who;
    endtask

    // Serves all pending requests in the order the round-robin rule dictates.
    task automatic serve(input int ar_delay, input int stall_at, input int stall_n);
        bit who;
        bit r;
        while (pend_ic || pend_dc) begin
            who = exp_pick(pend_ic, pend_dc);
            run_burst(who, who ? dc_addr : ic_addr, who ? dc_len : ic_len,
                      ar_delay, stall_at, stall_n, -1, r);
        end
    endtask

    task automatic do_reset();
        logic [DATA_WIDTH-1:0] d;
        @(negedge clk);
        rst = 1'b1;
        bus.ic_arvalid = 1'b0; bus.dc_arvalid = 1'b0;
        bus.mem_arready = 1'b0; bus.mem_rvalid = 1'b0;
        pend_ic = 1'b0; pend_dc = 1'b0;
        @(negedge clk);
        d = $urandom;
        bus.mem_rdata = d;
        #1;
        check_reset_outputs(d);
        @(negedge clk);
        rst = 1'b0;
        model_last = 1'b1;
        model_err  = 1'b0;
    endtask

    initial begin
        bit r;
        logic [DATA_WIDTH-1:0] d;
        rst = 1'b1;
        bus.ic_araddr = '0; bus.ic_arlen = '0; bus.ic_arvalid = 1'b0; bus.ic_rready = 1'b1;
        bus.dc_araddr = '0; bus.dc_arlen = '0; bus.dc_arvalid = 1'b0; bus.dc_rready = 1'b1;
        bus.mem_arready = 1'b0; bus.mem_rdata = '0; bus.mem_rvalid = 1'b0;
        pend_ic = 1'b0; pend_dc = 1'b0;
        do_reset();

        // IC alone, fixed address, 4 beats, memory ready at once.
        request(1, 0, 26'h0001040, 8'd4, '0, '0);
        serve(0, -1, 0);

        // Simultaneous requests after reset: IC first, then DC.
        do_reset();
        request(1, 1, 26'($urandom), 8'($urandom_range(1, 6)),
                      26'($urandom), 8'($urandom_range(1, 6)));
        serve(0, -1, 0);

        // IC alone, then a tie: the alternation now favours DC.
        request(1, 0, 26'($urandom), 8'($urandom_range(1, 6)), '0, '0);
        serve(0, -1, 0);
        request(1, 1, 26'($urandom), 8'($urandom_range(1, 6)),
                      26'($urandom), 8'($urandom_range(1, 6)));
        serve(0, -1, 0);

        // DC burst of 4 with rready withheld 3 cycles before beat 2.
        request(0, 1, '0, '0, 26'($urandom), 8'd4);
        serve(0, 1, 3);

        // DC burst with mem_arready withheld 5 cycles.
        request(0, 1, '0, '0, 26'($urandom), 8'($urandom_range(1, 6)));
        serve(5, -1, 0);

        // Zero-length IC request moves exactly one beat.
        request(1, 0, 26'($urandom), 8'd0, '0, '0);
        serve(0, -1, 0);

        // Spurious beat while idle.
        @(negedge clk);
        d = $urandom;
        bus.mem_rdata = d;
        bus.mem_rvalid = 1'b1;
        #1;
        chk("spur_ic_rvld", bus.ic_rvalid, 0);
        chk("spur_dc_rvld", bus.dc_rvalid, 0);
        chk("spur_rready",  bus.mem_rready, 1);
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        model_err = 1'b1;
        #1;
        chk("spur_err_set", err_spurious_r, 1);
        @(negedge clk);
        #1;
        chk("spur_err_sticky", err_spurious_r, 1);

        // Reset on beat 2 of a 4-beat IC burst.
        request(1, 0, 26'($urandom), 8'd4, '0, '0);
        run_burst(exp_pick(1, 0), ic_addr, ic_len, 0, -1, 0, 1, r);
        chk("midrst_taken", r, 1);
        pend_ic = 1'b0;

        // Pointer is back to its reset value: IC wins the tie again.
        request(1, 1, 26'($urandom), 8'($urandom_range(1, 6)),
                      26'($urandom), 8'($urandom_range(1, 6)));
        serve(0, -1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule : tb_mem_read_arbiter
`default_nettype wire
